lcd_reader: RTL

Read-side controller for the HD44780-style character LCD: performs bus reads of the status register (busy flag + address counter, RS=0) or the data register (DDRAM/CGRAM byte, RS=1) with RW=1. Sits beside the LCD text writer; the top level muxes RS/RW/EN to the LCD from this block while `lcd_own` is high. It also offers a busy-poll mode that repeats status reads until BF clears or a poll limit is reached. Uses the same 200/1600/200-cycle setup/enable/hold frame as the write path.

---
 rtl/lcd_reader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/lcd_reader.sv
// Read-side controller for an HD44780-style LCD: status/data register reads
// using a setup/enable/hold bus frame, with an optional busy-flag poll loop.
module lcd_reader #(
  parameter int T_SETUP  = 200,
  parameter int T_EN     = 1600,
  parameter int T_HOLD   = 200,
  parameter int POLL_MAX = 255,
  parameter int CNT_W    = 12
) (
  input  logic       LCDCLK,
  input  logic       PRESET,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic       rd_poll,
  output logic       rd_busy,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       rd_timeout,
  output logic       lcd_own,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  input  logic [7:0] LCD_DATA_IN
);

  typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, DONE} state_t;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
  localparam logic [7:0]       POLL_LIM   = 8'(POLL_MAX);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             rs_q, poll_q;
  logic [7:0]       shadow;
  logic [7:0]       poll_cnt;
  logic             phase_last;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    phase_last = 1'b0;
    case (state)
      SETUP:   phase_last = (cnt == SETUP_LAST);
      ENABLE:  phase_last = (cnt == EN_LAST);
      HOLD:    phase_last = (cnt == HOLD_LAST);
      default: phase_last = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge LCDCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a poll re-enters SETUP while BF is still set and reads remain
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_req) state_nxt = SETUP;
      SETUP:   if (phase_last) state_nxt = ENABLE;
      ENABLE:  if (phase_last) state_nxt = HOLD;
      HOLD:    if (phase_last)
                 state_nxt = (poll_q && shadow[7] && (poll_cnt < POLL_LIM)) ? SETUP : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Phase counter, request latch, bus capture and result register
  always_ff @(posedge LCDCLK) begin
    if (PRESET) begin
      cnt      <= '0;
      rs_q     <= 1'b0;
      poll_q   <= 1'b0;
      shadow   <= 8'h00;
      poll_cnt <= 8'h00;
      rd_data  <= 8'h00;
    end else begin
      if (state == IDLE || state_nxt != state) cnt <= '0;
      else                                      cnt <= cnt + CNT_W'(1);

      if (state == IDLE && rd_req) begin
        rs_q     <= rd_rs;
        poll_q   <= rd_poll & ~rd_rs;
        poll_cnt <= 8'h00;
      end

      // Sample on the last EN-high cycle, the latest point before EN falls
      if (state == ENABLE && phase_last) begin
        shadow   <= LCD_DATA_IN;
        poll_cnt <= sat_inc(poll_cnt);
      end

      if (state == HOLD && state_nxt == DONE) rd_data <= shadow;
    end
  end

  // Output decode; RS/RW stay asserted through DONE
  always_comb begin
    LCD_RS     = 1'b0;
    LCD_RW     = 1'b0;
    LCD_EN     = 1'b0;
    rd_valid   = 1'b0;
    rd_timeout = 1'b0;
    case (state)
      SETUP, HOLD: begin
        LCD_RS = rs_q;
        LCD_RW = 1'b1;
      end
      ENABLE: begin
        LCD_RS = rs_q;
        LCD_RW = 1'b1;
        LCD_EN = 1'b1;
      end
      DONE: begin
        LCD_RS     = rs_q;
        LCD_RW     = 1'b1;
        rd_valid   = 1'b1;
        rd_timeout = poll_q & shadow[7];
      end
      default: ;
    endcase
    rd_busy = (state != IDLE);
    lcd_own = (state != IDLE);
  end

endmodule
